// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage access controller.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam int TIMEOUT_DEF = 16;

    typedef struct packed {
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  reg_dest;
        logic        mem_to_reg;
        logic        reg_write;
    } mem_wb_t;

    localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data-memory bus between the MEM stage and data memory.
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_access_unit_mem_wb.sv
// MEM/WB pipeline register; holds when not loaded, loads a bubble on request.
module mem_wb_register
    import mips_mem_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_load,
    input  logic    i_bubble,
    input  mem_wb_t i_d,
    output mem_wb_t o_q
);

    mem_wb_t r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= MEM_WB_BUBBLE;
        end else if (i_load) begin
            r_q <= i_bubble ? MEM_WB_BUBBLE : i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: issues load/store bus transactions, stalls the front
// of the pipeline while one is outstanding, and drives the MEM/WB register.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_zero,
    input  logic [31:0] MEM_ALUresult,
    input  logic [31:0] MEM_ReadData2,
    input  logic [31:0] MEM_Branch_Addr,
    input  logic [4:0]  MEM_RegDest,
    input  logic        MEM_Branch,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic        MEM_MemtoReg,
    input  logic        MEM_RegWrite,
    mem_access_unit_if.master dmem,
    output logic        mem_stall,
    output logic        PCSrc,
    output logic [31:0] Branch_Target,
    output logic [31:0] MEMtoWB_ReadData,
    output logic [31:0] MEMtoWB_ALUresult,
    output logic [4:0]  MEMtoWB_RegDest,
    output logic        WB_MemtoReg,
    output logic        WB_RegWrite,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

    mem_state_t    r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_rdata;
    logic          r_timed_out;
    logic          r_req, r_we;
    logic [31:0]   r_addr, r_wdata;
    logic          r_misalign_err, r_bus_err;

    logic          w_access, w_misalign, w_start, w_timeout;
    logic          w_stall, w_load, w_bubble, w_no_wr;
    logic [31:0]   w_rd;
    mem_wb_t       w_d, w_q;

    assign w_access   = MEM_MemRead | MEM_MemWrite;
    assign w_misalign = (MEM_ALUresult[1:0] != 2'b00);

    always_comb begin
        w_next    = r_state;
        w_stall   = 1'b0;
        w_load    = 1'b1;
        w_bubble  = 1'b0;
        w_no_wr   = 1'b0;
        w_rd      = 32'd0;
        w_start   = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access && !w_misalign) begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                    w_start  = 1'b1;
                    w_next   = BUSY;
                end else if (w_access) begin
                    w_no_wr = 1'b1;
                end
            end
            BUSY: begin
                // MEM/WB already holds the bubble loaded on entry; just keep it.
                w_stall = 1'b1;
                w_load  = 1'b0;
                if (dmem.dmem_ack) begin
                    w_next = DONE;
                end else if (r_cnt == TC) begin
                    w_timeout = 1'b1;
                    w_next    = DONE;
                end
            end
            DONE: begin
                w_rd    = r_rdata;
                w_no_wr = r_timed_out;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_d            = MEM_WB_BUBBLE;
        w_d.read_data  = w_rd;
        w_d.alu_result = MEM_ALUresult;
        w_d.reg_dest   = MEM_RegDest;
        w_d.mem_to_reg = MEM_MemtoReg;
        w_d.reg_write  = MEM_RegWrite & ~w_no_wr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_rdata        <= 32'd0;
            r_timed_out    <= 1'b0;
            r_req          <= 1'b0;
            r_we           <= 1'b0;
            r_addr         <= 32'd0;
            r_wdata        <= 32'd0;
            r_misalign_err <= 1'b0;
            r_bus_err      <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_misalign_err <= (r_state == IDLE) && w_access && w_misalign;
            r_bus_err      <= w_timeout;
            if (w_start) begin
                r_req       <= 1'b1;
                r_we        <= MEM_MemWrite;
                r_addr      <= MEM_ALUresult;
                r_wdata     <= MEM_ReadData2;
                r_cnt       <= '0;
                r_timed_out <= 1'b0;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt + CW'(1);
                if (dmem.dmem_ack) begin
                    r_req   <= 1'b0;
                    r_rdata <= dmem.dmem_rdata;
                end else if (w_timeout) begin
                    r_req       <= 1'b0;
                    r_rdata     <= 32'd0;
                    r_timed_out <= 1'b1;
                end
            end
        end
    end

    mem_wb_register u_mem_wb (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_bubble (w_bubble),
        .i_d      (w_d),
        .o_q      (w_q)
    );

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_wdata = r_wdata;

    assign mem_stall         = w_stall;
    assign PCSrc             = MEM_Branch & MEM_zero & ~w_stall;
    assign Branch_Target     = MEM_Branch_Addr;
    assign MEMtoWB_ReadData  = w_q.read_data;
    assign MEMtoWB_ALUresult = w_q.alu_result;
    assign MEMtoWB_RegDest   = w_q.reg_dest;
    assign WB_MemtoReg       = w_q.mem_to_reg;
    assign WB_RegWrite       = w_q.reg_write;
    assign misalign_err      = r_misalign_err;
    assign bus_err           = r_bus_err;

endmodule
